regfile_write_demux: RTL and testbench

- Write-side counterpart of the read-select mux tree. It decodes a write-back address into one-hot enables and steers write data into one of NREG WIDTH-bit registers.
- Exposes all register contents, flattened, to the read-port mux trees.
- Keeps a pending-write scoreboard (set at issue, cleared at write-back) for hazard detection.
- Sits between the WB pipeline stage and the decode-stage read muxes.

---
 rtl/regfile_write_demux.sv | 106 ++++++++++
 tb/tb_regfile_write_demux.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/regfile_write_demux.sv
// regfile_write_demux
// Write-back side of the register file: decodes the write-back address into
// one-hot enables, stores WIDTH-bit registers, exposes them flattened to the
// read-port muxes, and tracks outstanding producers in a pending scoreboard.
// Register ZERO_REG is hardwired to zero and never becomes pending.
// Optional feature macro: WRITE_BYPASS_EN (write-through of wr_data onto
// regs_flat in the cycle of the write).
module regfile_write_demux #(
    parameter int unsigned WIDTH    = 64,
    parameter int unsigned ADDR_W   = 5,
    parameter int unsigned ZERO_REG = 31
) (
    input  logic                           clk,
    input  logic                           reset_n,
    input  logic                           wr_en,
    input  logic [ADDR_W-1:0]              wr_addr,
    input  logic [WIDTH-1:0]               wr_data,
    input  logic                           iss_en,
    input  logic [ADDR_W-1:0]              iss_addr,
    output logic [WIDTH*(2**ADDR_W)-1:0]   regs_flat,
    output logic [(2**ADDR_W)-1:0]         pending,
    output logic                           wr_ack,
    output logic                           wr_stray
);

    localparam int unsigned NREG = 2**ADDR_W;

    logic [NREG-1:0]  wr_sel;
    logic             wr_accept;
    logic [WIDTH-1:0] regs_q [NREG];
    logic [NREG-1:0]  pending_q, pending_d;
    logic             ack_q, ack_d;
    logic             stray_q, stray_d;

    // Address decode: one-hot write enable, the zero register never selected.
    always_comb begin
        wr_sel = '0;
        for (int unsigned r = 0; r < NREG; r++) begin
            wr_sel[r] = wr_en && (wr_addr == ADDR_W'(r)) && (r != ZERO_REG);
        end
        wr_accept = |wr_sel;
    end

    // Scoreboard next state: clear on accepted write, then set on issue so a
    // same-address issue wins over the completing write.
    always_comb begin
        pending_d = pending_q;
        if (wr_accept) begin
            pending_d[wr_addr] = 1'b0;
        end
        if (iss_en && (iss_addr != ADDR_W'(ZERO_REG))) begin
            pending_d[iss_addr] = 1'b1;
        end
        ack_d   = wr_accept;
        stray_d = wr_accept && !pending_q[wr_addr];
    end

    // Register storage: only the selected register captures wr_data.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int unsigned r = 0; r < NREG; r++) begin
                regs_q[r] <= '0;
            end
        end else begin
            for (int unsigned r = 0; r < NREG; r++) begin
                if (wr_sel[r]) begin
                    regs_q[r] <= wr_data;
                end
            end
        end
    end

    // Scoreboard and write-status pulses.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pending_q <= '0;
            ack_q     <= 1'b0;
            stray_q   <= 1'b0;
        end else begin
            pending_q <= pending_d;
            ack_q     <= ack_d;
            stray_q   <= stray_d;
        end
    end

    // Flattened read view; with bypass the slice being written shows wr_data.
    always_comb begin
        regs_flat = '0;
        for (int unsigned r = 0; r < NREG; r++) begin
`ifdef WRITE_BYPASS_EN
            if (wr_sel[r]) begin
                regs_flat[r*WIDTH +: WIDTH] = wr_data;
            end else begin
                regs_flat[r*WIDTH +: WIDTH] = regs_q[r];
            end
`else
            regs_flat[r*WIDTH +: WIDTH] = regs_q[r];
`endif
        end
    end

    assign pending  = pending_q;
    assign wr_ack   = ack_q;
    assign wr_stray = stray_q;

endmodule

// File: tb/tb_regfile_write_demux.sv
// Directed self-checking bench for regfile_write_demux (default parameters).
module tb_regfile_write_demux;

    localparam int unsigned W = 64;
    localparam int unsigned N = 32;

    logic           clk;
    logic           reset_n;
    logic           wr_en;
    logic [4:0]     wr_addr;
    logic [W-1:0]   wr_data;
    logic           iss_en;
    logic [4:0]     iss_addr;
    logic [W*N-1:0] regs_flat;
    logic [N-1:0]   pending;
    logic           wr_ack;
    logic           wr_stray;

    int unsigned total;
    int unsigned bad;
    logic [W-1:0] exp_regs [N];

    regfile_write_demux #(
        .WIDTH   (64),
        .ADDR_W  (5),
        .ZERO_REG(31)
    ) dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .wr_en    (wr_en),
        .wr_addr  (wr_addr),
        .wr_data  (wr_data),
        .iss_en   (iss_en),
        .iss_addr (iss_addr),
        .regs_flat(regs_flat),
        .pending  (pending),
        .wr_ack   (wr_ack),
        .wr_stray (wr_stray)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk_regs(input string tag);
        for (int r = 0; r < N; r++) begin
            chk($sformatf("%s_slice%0d", tag, r), regs_flat[r*W +: W], exp_regs[r]);
        end
    endtask

    task automatic chk_status(input string tag, input logic [N-1:0] p, input logic a, input logic s);
        chk({tag, "_pending"}, W'(pending), W'(p));
        chk({tag, "_ack"}, W'(wr_ack), W'(a));
        chk({tag, "_stray"}, W'(wr_stray), W'(s));
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        wr_en = 1'b0; wr_addr = '0; wr_data = '0;
        iss_en = 1'b0; iss_addr = '0;
    endtask

    initial begin
        total = 0;
        bad   = 0;
        for (int r = 0; r < N; r++) exp_regs[r] = '0;
        reset_n = 1'b0;
        idle();

        // Reset state before any clock edge
        #3;
        chk_regs("reset");
        chk_status("reset", '0, 1'b0, 1'b0);
        tick();
        tick();
        reset_n = 1'b1;

        // Write register 5
        tick();
        wr_en = 1'b1; wr_addr = 5'd5; wr_data = 64'hDEAD_BEEF_0123_4567;
        #1;
        chk("w5_before_edge", regs_flat[5*W +: W], '0);
        tick();
        idle();
        exp_regs[5] = 64'hDEAD_BEEF_0123_4567;
        chk_regs("w5");
        chk_status("w5", '0, 1'b1, 1'b1);
        tick();
        chk_status("w5_after", '0, 1'b0, 1'b0);

        // Write to the zero register is dropped
        wr_en = 1'b1; wr_addr = 5'd31; wr_data = '1;
        #1;
        chk("zr_same_cycle", regs_flat[31*W +: W], '0);
        tick();
        idle();
        chk_regs("zr");
        chk_status("zr", '0, 1'b0, 1'b0);

        // Issue to zero register never sets pending
        iss_en = 1'b1; iss_addr = 5'd31;
        tick();
        idle();
        chk_status("zr_iss", '0, 1'b0, 1'b0);

        // Scoreboard: issue 7, then write 7
        iss_en = 1'b1; iss_addr = 5'd7;
        tick();
        idle();
        chk_status("sb_iss7", 32'h0000_0080, 1'b0, 1'b0);
        wr_en = 1'b1; wr_addr = 5'd7; wr_data = 64'd42;
        tick();
        idle();
        exp_regs[7] = 64'd42;
        chk_regs("sb_wr7");
        chk_status("sb_wr7", '0, 1'b1, 1'b0);

        // Same-cycle collision on register 3: set wins
        iss_en = 1'b1; iss_addr = 5'd3;
        tick();
        chk_status("col_iss3", 32'h0000_0008, 1'b0, 1'b0);
        wr_en = 1'b1; wr_addr = 5'd3; wr_data = 64'd9;
        tick();
        idle();
        exp_regs[3] = 64'd9;
        chk_regs("col");
        chk_status("col", 32'h0000_0008, 1'b1, 1'b0);

        // Different addresses same cycle: issue 10, write 3
        iss_en = 1'b1; iss_addr = 5'd10;
        wr_en = 1'b1; wr_addr = 5'd3; wr_data = 64'd11;
        tick();
        idle();
        exp_regs[3] = 64'd11;
        chk("diff_r3", regs_flat[3*W +: W], exp_regs[3]);
        chk_status("diff", 32'h0000_0400, 1'b1, 1'b0);

        // Re-issue to an already-pending register
        iss_en = 1'b1; iss_addr = 5'd10;
        tick();
        idle();
        chk_status("reiss10", 32'h0000_0400, 1'b0, 1'b0);

        // Stray write to 12
        wr_en = 1'b1; wr_addr = 5'd12; wr_data = 64'h5;
        tick();
        idle();
        exp_regs[12] = 64'h5;
        chk("stray_r12", regs_flat[12*W +: W], exp_regs[12]);
        chk_status("stray", 32'h0000_0400, 1'b1, 1'b1);
        tick();
        chk_status("stray_after", 32'h0000_0400, 1'b0, 1'b0);

        // Bypass behaviour on register 2
        wr_en = 1'b1; wr_addr = 5'd2; wr_data = 64'd77;
        #1;
`ifdef WRITE_BYPASS_EN
        chk("byp_same_cycle", regs_flat[2*W +: W], 64'd77);
`else
        chk("byp_same_cycle", regs_flat[2*W +: W], 64'd0);
`endif
        chk("byp_other_slice", regs_flat[3*W +: W], exp_regs[3]);
        chk("byp_pending", W'(pending), W'(32'h0000_0400));
        tick();
        exp_regs[2] = 64'd77;
        chk_regs("byp");
        chk_status("byp", 32'h0000_0400, 1'b1, 1'b1);

        // Async reset between edges with a write in flight
        wr_en = 1'b1; wr_addr = 5'd20; wr_data = 64'h55;
        #2;
        reset_n = 1'b0;
        #1;
        for (int r = 0; r < N; r++) exp_regs[r] = '0;
        chk_regs("arst");
        chk_status("arst", '0, 1'b0, 1'b0);
        tick();
        chk_regs("arst_edge");
        chk_status("arst_edge", '0, 1'b0, 1'b0);

        // First edge after release accepts the write
        reset_n = 1'b1;
        tick();
        idle();
        exp_regs[20] = 64'h55;
        chk_regs("post_rst");
        chk_status("post_rst", '0, 1'b1, 1'b1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
